// File: rtl/tmds_period_ctrl.sv
// Video timing and pixel-flow controller that feeds three TMDS channel encoders.
// Optional colour-bar generator enabled by defining TMDS_PERIOD_CTRL_TESTPAT_EN.
module tmds_period_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
`ifdef TMDS_PERIOD_CTRL_TESTPAT_EN
  input  logic        test_mode,
`endif
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [23:0] enc_data,
  output logic        enc_de,
  output logic [5:0]  enc_ctrl,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CW      = 12;

  localparam logic [CW-1:0] HActEnd   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HFpEnd    = CW'(H_ACTIVE + H_FP - 1);
  localparam logic [CW-1:0] HSyncEnd  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] HLast     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] VAct      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VSyncBeg  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSyncStop = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {StActive, StFront, StSync, StBack} hstate_e;

  hstate_e         state_q, state_d;
  logic [CW-1:0]   h_q, h_d, v_q, v_d;
  logic            px_active, hsync, vsync, uf_event, tp_on;
  logic [23:0]     tp_colour, data_d;

  always_comb begin
    h_d     = h_q + 12'd1;
    v_d     = v_q;
    state_d = state_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 12'd1;
    end
    unique case (state_q)
      StActive: if (h_q == HActEnd)  state_d = StFront;
      StFront:  if (h_q == HFpEnd)   state_d = StSync;
      StSync:   if (h_q == HSyncEnd) state_d = StBack;
      StBack:   if (h_q == HLast)    state_d = StActive;
      default:                       state_d = StActive;
    endcase
  end

`ifdef TMDS_PERIOD_CTRL_TESTPAT_EN
  localparam logic [CW-1:0] BarW = CW'(H_ACTIVE / 8);
  logic [CW-1:0] bar_raw;
  logic [2:0]    bar_idx;

  assign tp_on   = test_mode;
  assign bar_raw = h_q / BarW;
  // Guard against a remainder when H_ACTIVE is not a multiple of 8.
  assign bar_idx = (bar_raw > 12'd7) ? 3'd7 : bar_raw[2:0];

  always_comb begin
    tp_colour = 24'h000000;
    case (bar_idx)
      3'd0:    tp_colour = 24'hFFFFFF;
      3'd1:    tp_colour = 24'hFFFF00;
      3'd2:    tp_colour = 24'h00FFFF;
      3'd3:    tp_colour = 24'h00FF00;
      3'd4:    tp_colour = 24'hFF00FF;
      3'd5:    tp_colour = 24'hFF0000;
      3'd6:    tp_colour = 24'h0000FF;
      default: tp_colour = 24'h000000;
    endcase
  end
`else
  assign tp_on     = 1'b0;
  assign tp_colour = 24'h000000;
`endif

  assign px_active = (state_q == StActive) && (v_q < VAct);
  assign hsync     = (state_q == StSync) ? HS_POL : ~HS_POL;
  assign vsync     = (v_q >= VSyncBeg && v_q < VSyncStop) ? VS_POL : ~VS_POL;
  assign pix_ready = px_active && pix_valid && !tp_on;
  assign uf_event  = px_active && !pix_valid && !tp_on;

  always_comb begin
    data_d = 24'h000000;
    if (px_active) begin
      if (tp_on)          data_d = tp_colour;
      else if (pix_valid) data_d = pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StActive;
      h_q         <= '0;
      v_q         <= VLast;
      enc_de      <= 1'b0;
      enc_data    <= 24'h000000;
      enc_ctrl    <= {4'b0000, ~VS_POL, ~HS_POL};
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      enc_de      <= px_active;
      enc_data    <= data_d;
      enc_ctrl    <= px_active ? 6'b000000 : {4'b0000, vsync, hsync};
      frame_start <= px_active && (h_q == '0) && (v_q == '0);
      // A new event takes priority over a simultaneous clear.
      underflow   <= uf_event | (underflow & ~underflow_clr);
    end
  end

endmodule

// File: tb/tb_tmds_period_ctrl.sv
// Bench for tmds_period_ctrl: a small-timing instance checked against a position-based
// reference model, plus a default-parameter instance for line-level timing.
module tb_tmds_period_ctrl;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3, HT = HA + HFP + HSW + HBP;
  localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1, VT = VA + VFP + VSW + VBP;
  localparam bit HSP = 1'b1, VSP = 1'b0;
  localparam logic [5:0] RST_CTRL = 6'b000010;

  logic        clk = 1'b0, rst = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0, underflow_clr = 1'b0, test_mode = 1'b0;
  logic        pix_ready, enc_de, frame_start, underflow;
  logic [23:0] enc_data;
  logic [5:0]  enc_ctrl;

  logic [23:0] d2_data = 24'h123456;
  logic        d2_valid = 1'b1, d2_clr = 1'b0;
  logic        d2_ready, d2_de, d2_fs, d2_uf;
  logic [23:0] d2_enc;
  logic [5:0]  d2_ctrl;

  int checks = 0, failures = 0;
  int n = 0;
  logic        exp_de, exp_fs, exp_uf, exp_ready;
  logic [23:0] exp_data;
  logic [5:0]  exp_ctrl;

  always #5 clk = ~clk;

  tmds_period_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef TMDS_PERIOD_CTRL_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .enc_data(enc_data), .enc_de(enc_de), .enc_ctrl(enc_ctrl),
    .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  tmds_period_ctrl dut2 (
    .clk(clk), .rst(rst),
`ifdef TMDS_PERIOD_CTRL_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .pix_data(d2_data), .pix_valid(d2_valid), .pix_ready(d2_ready),
    .enc_data(d2_enc), .enc_de(d2_de), .enc_ctrl(d2_ctrl),
    .frame_start(d2_fs), .underflow(d2_uf), .underflow_clr(d2_clr)
  );

  function automatic int m_h(input int pos);
    return pos % HT;
  endfunction

  function automatic int m_line(input int pos);
    return (VT - 1 + pos / HT) % VT;
  endfunction

  function automatic logic m_active(input int pos);
    return (m_h(pos) < HA) && (m_line(pos) < VA);
  endfunction

  function automatic logic [23:0] m_bar(input int h);
    case (h / (HA / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic apply(input logic v, input logic [23:0] d, input logic c);
    pix_valid = v;
    pix_data = d;
    underflow_clr = c;
    exp_ready = m_active(n) && v && !test_mode;
    #1;
  endtask

  // Advance one clock and derive what the outputs must show for the position just left.
  task automatic tick();
    int h, ln;
    logic act, hs, vs;
    @(posedge clk);
    h = m_h(n);
    ln = m_line(n);
    act = m_active(n);
    hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HSP : !HSP;
    vs = (ln >= VA + VFP && ln < VA + VFP + VSW) ? VSP : !VSP;
    exp_de = act;
    exp_data = !act ? 24'h0 : test_mode ? m_bar(h) : pix_valid ? pix_data : 24'h0;
    exp_ctrl = act ? 6'b0 : {4'b0, vs, hs};
    exp_fs = act && h == 0 && ln == 0;
    if (act && !pix_valid && !test_mode) exp_uf = 1'b1;
    else if (underflow_clr) exp_uf = 1'b0;
    n++;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    exp_uf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pix_valid = 1'b1;
    pix_data = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", pix_ready); end
    checks++; if (enc_de !== 1'b0) begin failures++; $display("FAIL reset_de got=%b want=0", enc_de); end
    checks++; if (enc_data !== 24'h0) begin failures++; $display("FAIL reset_data got=%h want=0", enc_data); end
    checks++; if (enc_ctrl !== RST_CTRL) begin failures++; $display("FAIL reset_ctrl got=%b want=%b", enc_ctrl, RST_CTRL); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_uf got=%b want=0", underflow); end
    checks++; if (d2_ctrl !== 6'b000011) begin failures++; $display("FAIL reset_ctrl_dflt got=%b want=000011", d2_ctrl); end
    #1 rst = 1'b1;
    n = 0;
    exp_uf = 1'b0;
  endtask

  task automatic test_first_pixel();
    int k;
    logic [23:0] d;
    do_reset();
    k = 0;
    d = '0;
    for (int i = 1; i <= 3 * HT; i++) begin
      d = $urandom;
      apply(1'b1, d, 1'b0);
      tick();
      if (enc_de) begin k = i; break; end
    end
    checks++; if (k != HT + 1) begin failures++; $display("FAIL first_de_latency got=%0d want=%0d", k, HT + 1); end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL first_fs got=%b want=1", frame_start); end
    checks++; if (enc_data !== d) begin failures++; $display("FAIL first_data got=%h want=%h", enc_data, d); end
  endtask

  task automatic test_random(input int cycles);
    logic v, c;
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      v = ($urandom % 8) != 0;
      c = ($urandom % 16) == 0;
      apply(v, $urandom, c);
      checks++; if (pix_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, pix_ready, exp_ready); end
      tick();
      checks++; if (enc_de !== exp_de) begin failures++; $display("FAIL rnd_de n=%0d got=%b want=%b", n, enc_de, exp_de); end
      checks++; if (enc_data !== exp_data) begin failures++; $display("FAIL rnd_data n=%0d got=%h want=%h", n, enc_data, exp_data); end
      checks++; if (enc_ctrl !== exp_ctrl) begin failures++; $display("FAIL rnd_ctrl n=%0d got=%b want=%b", n, enc_ctrl, exp_ctrl); end
      checks++; if (frame_start !== exp_fs) begin failures++; $display("FAIL rnd_fs n=%0d got=%b want=%b", n, frame_start, exp_fs); end
      checks++; if (underflow !== exp_uf) begin failures++; $display("FAIL rnd_uf n=%0d got=%b want=%b", n, underflow, exp_uf); end
    end
  endtask

  task automatic test_underflow();
    int guard;
    do_reset();
    guard = 0;
    while (!(m_line(n) == 1 && m_h(n) == 5) && guard < 4 * VT * HT) begin
      apply(1'b1, $urandom, 1'b0); tick(); guard++;
    end
    apply(1'b0, 24'hABCDEF, 1'b0);
    tick();
    checks++; if (enc_de !== 1'b1) begin failures++; $display("FAIL uf_de got=%b want=1", enc_de); end
    checks++; if (enc_data !== 24'h0) begin failures++; $display("FAIL uf_black got=%h want=0", enc_data); end
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%b want=1", underflow); end
    for (int i = 0; i < 2 * HT; i++) begin
      apply(1'b1, $urandom, 1'b0);
      tick();
      checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_hold i=%0d got=%b want=1", i, underflow); end
    end
    apply(1'b1, $urandom, 1'b1);
    tick();
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_clear got=%b want=0", underflow); end
    guard = 0;
    while (!m_active(n) && guard < 4 * VT * HT) begin
      apply(1'b1, $urandom, 1'b0); tick(); guard++;
    end
    apply(1'b0, $urandom, 1'b1);
    tick();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_set_wins got=%b want=1", underflow); end
    guard = 0;
    while (m_active(n) && guard < 4 * VT * HT) begin
      apply(1'b1, $urandom, 1'b0); tick(); guard++;
    end
    apply(1'b0, $urandom, 1'b1);
    tick();
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_blank_clear got=%b want=0", underflow); end
  endtask

  task automatic test_midline_reset();
    int guard, k;
    do_reset();
    guard = 0;
    while (!(m_line(n) == 2 && m_h(n) == 10) && guard < 4 * VT * HT) begin
      apply(1'b1, $urandom, 1'b0); tick(); guard++;
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b want=0", pix_ready); end
    checks++; if (enc_de !== 1'b0) begin failures++; $display("FAIL mid_de got=%b want=0", enc_de); end
    checks++; if (enc_data !== 24'h0) begin failures++; $display("FAIL mid_data got=%h want=0", enc_data); end
    checks++; if (enc_ctrl !== RST_CTRL) begin failures++; $display("FAIL mid_ctrl got=%b want=%b", enc_ctrl, RST_CTRL); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    exp_uf = 1'b0;
    k = 0;
    for (int i = 1; i <= 3 * HT; i++) begin
      apply(1'b1, $urandom, 1'b0);
      tick();
      if (enc_de) begin k = i; break; end
    end
    checks++; if (k != HT + 1) begin failures++; $display("FAIL mid_restart_latency got=%0d want=%0d", k, HT + 1); end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL mid_restart_fs got=%b want=1", frame_start); end
  endtask

  task automatic test_default_line();
    int k, t, de_cnt, hs_cnt;
    logic prev_de;
    do_reset();
    k = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); #1;
      if (d2_de) begin k = i; break; end
    end
    checks++; if (k != 801) begin failures++; $display("FAIL dflt_latency got=%0d want=801", k); end
    checks++; if (d2_fs !== 1'b1) begin failures++; $display("FAIL dflt_fs got=%b want=1", d2_fs); end
    checks++; if (d2_enc !== 24'h123456) begin failures++; $display("FAIL dflt_data got=%h want=123456", d2_enc); end
    t = 0; de_cnt = 1; hs_cnt = 0; prev_de = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      t++;
      if (d2_de && !prev_de) break;
      if (d2_de) de_cnt++;
      if (!d2_de && d2_ctrl[0] == 1'b0) hs_cnt++;
      prev_de = d2_de;
    end
    checks++; if (t != 800) begin failures++; $display("FAIL dflt_line_period got=%0d want=800", t); end
    checks++; if (de_cnt != 640) begin failures++; $display("FAIL dflt_de_count got=%0d want=640", de_cnt); end
    checks++; if (hs_cnt != 96) begin failures++; $display("FAIL dflt_hsync_width got=%0d want=96", hs_cnt); end
  endtask

`ifdef TMDS_PERIOD_CTRL_TESTPAT_EN
  task automatic test_testpat();
    test_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 2 * HT; i++) begin
      apply($urandom % 2 == 0, $urandom, 1'b0);
      checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL tp_ready n=%0d got=%b want=0", n, pix_ready); end
      tick();
      checks++; if (enc_data !== exp_data) begin failures++; $display("FAIL tp_data n=%0d got=%h want=%h", n, enc_data, exp_data); end
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL tp_uf n=%0d got=%b want=0", n, underflow); end
    end
    do_reset();
    for (int i = 1; i <= 801 + 640; i++) begin
      @(posedge clk); #1;
      if (i == 801) begin
        checks++; if (d2_enc !== 24'hFFFFFF) begin failures++; $display("FAIL tp_px0 got=%h want=FFFFFF", d2_enc); end
      end
      if (i == 881) begin
        checks++; if (d2_enc !== 24'hFFFF00) begin failures++; $display("FAIL tp_px80 got=%h want=FFFF00", d2_enc); end
      end
      if (i == 1440) begin
        checks++; if (d2_enc !== 24'h000000 || d2_de !== 1'b1) begin failures++; $display("FAIL tp_px639 got=%h de=%b want=000000 de=1", d2_enc, d2_de); end
      end
    end
    test_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_pixel();
    test_random(3 * VT * HT);
    test_underflow();
    test_midline_reset();
    test_default_line();
`ifdef TMDS_PERIOD_CTRL_TESTPAT_EN
    test_testpat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tmds_period_ctrl.md
TMDS_PERIOD_CTRL -- requirements
Module: tmds_period_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal blanking segments in pixels.
REQ-003 SHALL have parameters V_ACTIVE / V_FP / V_SYNC / V_BP, defaults 480 / 10 / 2 / 33, vertical segments in lines.
REQ-004 SHALL have parameters HS_POL / VS_POL, default 0 / 0, sync level during the sync interval (0 = active-low).
REQ-005 clk  in  1  pixel clock, sole clock domain.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 pix_data  in  24  RGB pixel {R[23:16],G[15:8],B[7:0]}.
REQ-008 pix_valid  in  1  pix_data is valid.
REQ-009 pix_ready  out  1  pixel consumed this cycle.
REQ-010 enc_data  out  24  per-channel encoder data_in {ch2,ch1,ch0}.
REQ-011 enc_de  out  1  encoder data_en, common to all three channels.
REQ-012 enc_ctrl  out  6  encoder control {ch2[1:0],ch1[1:0],ch0[1:0]}.
REQ-013 frame_start  out  1  one-cycle pulse on the first active pixel of a frame.
REQ-014 underflow  out  1  sticky; set when a pixel is needed and pix_valid=0.
REQ-015 underflow_clr  in  1  clears underflow.

Function
REQ-016 SHALL keep an h counter 0..H_TOTAL-1 (H_TOTAL = sum of H_*) and a v counter 0..V_TOTAL-1, with v advancing when h wraps.
REQ-017 SHALL use horizontal states ACTIVE (h<H_ACTIVE) -> FRONT -> SYNC -> BACK -> ACTIVE, with state transitions only on segment boundaries.
REQ-018 SHALL treat a line as active only when v<V_ACTIVE; on all other lines ACTIVE behaves as blanking.
REQ-019 pix_ready SHALL be combinational = (state ACTIVE AND active line AND pix_valid); a pixel transfers when pix_ready=1.
REQ-020 All encoder outputs SHALL be registered, giving one cycle of latency from the counter position to the outputs.
REQ-021 In an active pixel, enc_de=1, enc_data=pix_data (ch2=R, ch1=G, ch0=B), and enc_ctrl=0.
REQ-022 In an active pixel with pix_valid=0, enc_de=1 and enc_data=0 (black), and underflow SHALL be set the same cycle.
REQ-023 In blanking, enc_de=0, enc_data=0, and enc_ctrl[1:0]={vsync,hsync}, with enc_ctrl[5:2]=0.
REQ-024 hsync SHALL be HS_POL while in the SYNC state, otherwise ~HS_POL.
REQ-025 vsync SHALL be VS_POL for lines V_ACTIVE+V_FP .. +V_SYNC-1, otherwise ~VS_POL, switching at h=0.
REQ-026 frame_start SHALL be aligned with the enc_de rising edge at h=0, v=0.
REQ-027 If underflow_clr and a new underflow event occur in the same cycle, underflow SHALL be 1 (set wins).
REQ-028 Counters SHALL be wide enough for H_TOTAL/V_TOTAL up to 4095 with no truncation; wrap is exact at TOTAL-1.

Reset
REQ-029 With rst=0, SHALL force h=0, v=V_TOTAL-1 (last blanking line), pix_ready=0, enc_de=0, enc_data=0, enc_ctrl={4'b0,~VS_POL,~HS_POL}, frame_start=0, and underflow=0.
REQ-030 After reset release, the first active pixel SHALL occur after exactly H_TOTAL cycles, followed by frame_start.
REQ-031 A reset asserted mid-line SHALL abort immediately; no partial pixel is consumed afterward.

Configuration
REQ-032 Macro TMDS_PERIOD_CTRL_TESTPAT_EN SHALL add an input test_mode (1 bit).
REQ-033 With the macro defined and test_mode=1, active pixels SHALL be 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black at 8'hFF/8'h00 levels), pix_ready=0, and underflow never set.
REQ-034 Without the macro, the test_mode port and the generator SHALL be absent, with behaviour per REQ-019..REQ-027.

Verification
REQ-035 Reset, then pix_valid=1 constant -> first enc_de=1 exactly H_TOTAL+1 cycles after reset release, with frame_start aligned to it.
REQ-036 Default parameters, full frame -> 640x480 enc_de cycles, 800 cycles per line, hsync low for 96 cycles, vsync low for 2 lines of 800 cycles.
REQ-037 Drop pix_valid for 1 cycle mid-line -> enc_data=0 that cycle with enc_de=1, underflow=1 held until underflow_clr.
REQ-038 Assert underflow_clr in the same cycle as a new underflow -> underflow remains 1.
REQ-039 Assert rst at h=300 of an active line -> outputs at reset values immediately, then restart per REQ-030.
REQ-040 With TMDS_PERIOD_CTRL_TESTPAT_EN and test_mode=1 -> pixel 0 is 24'hFFFFFF, pixel 80 is 24'hFFFF00, pixel 639 is 0, pix_ready stays 0.
